// File: rtl/modem_mag_avg_if.sv
// Sample-in / magnitude-out bundle for modem_mag_avg.
// master drives I/Q samples and clear; slave is the estimator.
interface modem_mag_avg_if #(
    parameter int unsigned GW_DATA = 16
);
    logic                 s_valid;
    logic [GW_DATA-1:0]   s_i;
    logic [GW_DATA-1:0]   s_q;
    logic                 s_clr;
    logic                 m_valid;
    logic [GW_DATA-1:0]   m_mag;
    logic                 m_avg_valid;
    logic [GW_DATA-1:0]   m_avg;

    modport master (
        output s_valid, s_i, s_q, s_clr,
        input  m_valid, m_mag, m_avg_valid, m_avg
    );

    modport slave (
        input  s_valid, s_i, s_q, s_clr,
        output m_valid, m_mag, m_avg_valid, m_avg
    );
endinterface

// File: rtl/modem_mag_avg.sv
// Complex-magnitude estimator (alpha-max + 3/8 beta-min) in a 3-stage pipe,
// followed by a power-of-two block averager of the magnitude stream.
module modem_mag_avg #(
    parameter int unsigned GW_DATA  = 16,
    parameter int unsigned AVG_LOG2 = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    modem_mag_avg_if.slave     bus
);
    localparam int unsigned ACC_W = GW_DATA + AVG_LOG2;
    localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;

    // Stage 1 combinational: absolute values; the most negative code maps to 2^(GW_DATA-1).
    logic [GW_DATA-1:0] w_abs_i;
    logic [GW_DATA-1:0] w_abs_q;

    always_comb begin
        w_abs_i = bus.s_i;
        w_abs_q = bus.s_q;
        if (bus.s_i[GW_DATA-1]) begin
            w_abs_i = (~bus.s_i) + GW_DATA'(1);
        end
        if (bus.s_q[GW_DATA-1]) begin
            w_abs_q = (~bus.s_q) + GW_DATA'(1);
        end
    end

    logic               r_v1;
    logic [GW_DATA-1:0] r_abs_i;
    logic [GW_DATA-1:0] r_abs_q;

    // Stage 1 register: rail magnitudes with their valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1    <= 1'b0;
            r_abs_i <= '0;
            r_abs_q <= '0;
        end else begin
            r_v1 <= bus.s_valid;
            if (bus.s_valid) begin
                r_abs_i <= w_abs_i;
                r_abs_q <= w_abs_q;
            end
        end
    end

    logic               r_v2;
    logic [GW_DATA-1:0] r_mx;
    logic [GW_DATA-1:0] r_mn;

    // Stage 2 register: sort into max/min (tie gives the common value to both).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2 <= 1'b0;
            r_mx <= '0;
            r_mn <= '0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                if (r_abs_i >= r_abs_q) begin
                    r_mx <= r_abs_i;
                    r_mn <= r_abs_q;
                end else begin
                    r_mx <= r_abs_q;
                    r_mn <= r_abs_i;
                end
            end
        end
    end

    // Stage 3 combinational: max + min/4 + min/8; bounded by 1.375*2^(GW_DATA-1), no overflow.
    logic [GW_DATA-1:0] w_mag;

    always_comb begin
        w_mag = r_mx + (r_mn >> 2) + (r_mn >> 3);
    end

    logic               r_m_valid;
    logic [GW_DATA-1:0] r_m_mag;

    // Stage 3 register: the magnitude output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_mag   <= '0;
        end else begin
            r_m_valid <= r_v2;
            if (r_v2) begin
                r_m_mag <= w_mag;
            end
        end
    end

    // Averager datapath: running window sum including the sample now on m_mag.
    logic [ACC_W-1:0]    r_acc;
    logic [AVG_LOG2-1:0] r_cnt;
    logic [ACC_W-1:0]    w_sum;
    logic                w_last;

    always_comb begin
        w_sum  = r_acc + ACC_W'(r_m_mag);
        w_last = (r_cnt == CNT_LAST);
    end

    logic               r_avg_valid;
    logic [GW_DATA-1:0] r_avg;

    // Window integrator: clear beats a coincident sample; closing sample emits the mean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_avg_valid <= 1'b0;
            r_avg       <= '0;
        end else begin
            r_avg_valid <= 1'b0;
            if (bus.s_clr) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_m_valid) begin
                if (w_last) begin
                    r_avg       <= GW_DATA'(w_sum >> AVG_LOG2);
                    r_avg_valid <= 1'b1;
                    r_acc       <= '0;
                    r_cnt       <= '0;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + AVG_LOG2'(1);
                end
            end
        end
    end

    assign bus.m_valid     = r_m_valid;
    assign bus.m_mag       = r_m_mag;
    assign bus.m_avg_valid = r_avg_valid;
    assign bus.m_avg       = r_avg;

endmodule
